vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 60 ++++++
 rtl/vram_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: CPU write/read ports, LCD read port,
// clear control and the dual-port VRAM pins.
`timescale 1ns/1ps
interface vram_arbiter_if;
    logic       cpu_wr_valid;
    logic       cpu_wr_ready;
    logic [9:0] cpu_wr_addr;
    logic [7:0] cpu_wr_data;

    logic       cpu_rd_valid;
    logic       cpu_rd_ready;
    logic [9:0] cpu_rd_addr;
    logic       cpu_rd_rvalid;
    logic [7:0] cpu_rd_rdata;

    logic       lcd_rd_valid;
    logic       lcd_rd_ready;
    logic [9:0] lcd_rd_addr;
    logic       lcd_rd_rvalid;
    logic [7:0] lcd_rd_rdata;

    logic       clr_start;
    logic       clr_busy;

    logic       v_cea;
    logic [9:0] v_ada;
    logic [7:0] v_din;
    logic       v_ceb;
    logic [9:0] v_adb;
    logic       v_oce;
    logic       v_reseta;
    logic       v_resetb;
    logic [7:0] v_dout;

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        input  cpu_rd_valid, cpu_rd_addr,
        input  lcd_rd_valid, lcd_rd_addr,
        input  clr_start,
        input  v_dout,
        output cpu_wr_ready,
        output cpu_rd_ready, cpu_rd_rvalid, cpu_rd_rdata,
        output lcd_rd_ready, lcd_rd_rvalid, lcd_rd_rdata,
        output clr_busy,
        output v_cea, v_ada, v_din, v_ceb, v_adb, v_oce, v_reseta, v_resetb
    );

    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
        output cpu_rd_valid, cpu_rd_addr,
        output lcd_rd_valid, lcd_rd_addr,
        output clr_start,
        output v_dout,
        input  cpu_wr_ready,
        input  cpu_rd_ready, cpu_rd_rvalid, cpu_rd_rdata,
        input  lcd_rd_ready, lcd_rd_rvalid, lcd_rd_rdata,
        input  clr_busy,
        input  v_cea, v_ada, v_din, v_ceb, v_adb, v_oce, v_reseta, v_resetb
    );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: CPU writes and the clear engine share the write port,
// CPU and LCD reads share the read port with anti-starvation for the CPU.
`timescale 1ns/1ps
module vram_arbiter #(
    parameter int unsigned READ_LAT   = 2,
    parameter int unsigned STARVE_MAX = 4,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input logic            MEMORY_CLK,
    input logic            rst_n,
    vram_arbiter_if.slave  bus
);

    localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_clr_cnt;
    logic        w_clr_last;
    logic        w_wr_accept;

    logic        r_cea;
    logic [9:0]  r_ada;
    logic [7:0]  r_din;

    logic [3:0]  r_starve;
    logic        w_lcd_gnt;
    logic        w_cpu_gnt;
    logic        r_ceb;
    logic [9:0]  r_adb;

    logic [READ_LAT:0] r_tag_v;
    logic [READ_LAT:0] r_tag_lcd;
    logic        w_ret_cpu;
    logic        w_ret_lcd;
    logic [7:0]  r_cpu_rdata;
    logic [7:0]  r_lcd_rdata;

    // ---------------- write side ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_clr_last  = 1'b0;
        unique case (r_state)
            ST_IDLE:  if (bus.clr_start) w_state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                w_clr_last = (r_clr_cnt == 10'h3FF);
                if (w_clr_last) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.cpu_wr_ready = (r_state == ST_IDLE) && !bus.clr_start;
    assign w_wr_accept      = bus.cpu_wr_valid && bus.cpu_wr_ready;
    assign bus.clr_busy     = (r_state == ST_CLEAR);

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_cea     <= 1'b0;
            r_ada     <= '0;
            r_din     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cea   <= w_wr_accept;
            if (w_wr_accept) begin
                r_ada <= bus.cpu_wr_addr;
                r_din <= bus.cpu_wr_data;
            end
            if (r_state == ST_CLEAR)
                r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 10'd1;
        end
    end

    // Clear engine owns the write port outright while busy; no CPU write is
    // ever pending then because acceptance requires IDLE.
    assign bus.v_cea = (r_state == ST_CLEAR) ? 1'b1      : r_cea;
    assign bus.v_ada = (r_state == ST_CLEAR) ? r_clr_cnt : r_ada;
    assign bus.v_din = (r_state == ST_CLEAR) ? FILL_CHAR : r_din;

    // ---------------- read side ----------------
    assign w_lcd_gnt = bus.lcd_rd_valid &&
                       !(bus.cpu_rd_valid && (r_starve == LP_STARVE_MAX));
    assign w_cpu_gnt = bus.cpu_rd_valid && !w_lcd_gnt;

    assign bus.lcd_rd_ready = w_lcd_gnt;
    assign bus.cpu_rd_ready = w_cpu_gnt;

    always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_starve    <= '0;
            r_ceb       <= 1'b0;
            r_adb       <= '0;
            r_tag_v     <= '0;
            r_tag_lcd   <= '0;
            r_cpu_rdata <= '0;
            r_lcd_rdata <= '0;
        end else begin
            if (!bus.cpu_rd_valid || w_cpu_gnt)
                r_starve <= '0;
            else if (w_lcd_gnt && (r_starve != LP_STARVE_MAX))
                r_starve <= r_starve + 4'd1;

            r_ceb <= w_lcd_gnt || w_cpu_gnt;
            if (w_lcd_gnt)
                r_adb <= bus.lcd_rd_addr;
            else if (w_cpu_gnt)
                r_adb <= bus.cpu_rd_addr;

            r_tag_v   <= {r_tag_v[READ_LAT-1:0],   w_lcd_gnt || w_cpu_gnt};
            r_tag_lcd <= {r_tag_lcd[READ_LAT-1:0], w_lcd_gnt};

            if (w_cpu_ret_hold()) r_cpu_rdata <= bus.v_dout;
            if (w_ret_lcd)        r_lcd_rdata <= bus.v_dout;
        end
    end

    function automatic logic w_cpu_ret_hold();
        return w_ret_cpu;
    endfunction

    assign bus.v_ceb = r_ceb;
    assign bus.v_adb = r_adb;

    // Tag stage READ_LAT lines up with v_dout for the matching grant.
    assign w_ret_cpu = r_tag_v[READ_LAT] && !r_tag_lcd[READ_LAT];
    assign w_ret_lcd = r_tag_v[READ_LAT] &&  r_tag_lcd[READ_LAT];

    assign bus.cpu_rd_rvalid = w_ret_cpu;
    assign bus.lcd_rd_rvalid = w_ret_lcd;
    assign bus.cpu_rd_rdata  = w_ret_cpu ? bus.v_dout : r_cpu_rdata;
    assign bus.lcd_rd_rdata  = w_ret_lcd ? bus.v_dout : r_lcd_rdata;

    // ---------------- static pins ----------------
    assign bus.v_oce    = 1'b1;
    assign bus.v_reseta = !rst_n;
    assign bus.v_resetb = !rst_n;

endmodule
